// File: rtl/q_table_updater.sv
// Q-table write side: one read-modify-write per accepted update request.
// Q_new = Q + alpha*(r + gamma*maxQ' - Q), with alpha = 2^-ALPHA_SHIFT
// and gamma = 1 - 2^-GAMMA_SHIFT, saturated to the unsigned Q range.
module q_table_updater #(
    parameter int Q_W         = 8,
    parameter int S_W         = 15,
    parameter int ADDR_W      = 18,
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [S_W-1:0]    state_idx,
    input  logic [3:0]        action,
    input  logic [7:0]        reward,
    input  logic [Q_W-1:0]    max_q,
    input  logic              terminal,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [Q_W-1:0]    q_new,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [Q_W-1:0]    mem_rd_data,
    output logic              mem_wr_en,
    output logic [Q_W-1:0]    mem_wr_data
);

    // Internal arithmetic width: covers target range -128..382 and the delta
    // range -383..382 with headroom.
    localparam int CW = Q_W + 3;

    typedef enum logic [2:0] {IDLE, RD, CAP, CALC, WR, DONE} state_t;

    state_t state, state_nx;

    logic                  accept;
    logic                  bad_action;
    logic [ADDR_W-1:0]     addr_calc;

    logic [ADDR_W-1:0]     addr_r;
    logic signed [7:0]     reward_r;
    logic [Q_W-1:0]        max_q_r;
    logic                  terminal_r;
    logic [Q_W-1:0]        q_old_r;
    logic [Q_W-1:0]        result_r;
    logic [Q_W-1:0]        q_new_r;
    logic                  err_r;

    logic [Q_W-1:0]        g_u;
    logic signed [CW-1:0]  g_s;
    logic signed [CW-1:0]  target_s;
    logic signed [CW-1:0]  q_old_s;
    logic signed [CW-1:0]  delta_s;
    logic signed [CW-1:0]  step_s;
    logic signed [CW-1:0]  sum_s;
    logic [Q_W-1:0]        calc_result;

    // Clamp a signed intermediate into the unsigned Q entry range.
    function automatic logic [Q_W-1:0] sat_q(input logic signed [CW-1:0] v);
        logic signed [CW-1:0] q_max;
        q_max = $signed({{(CW-Q_W){1'b0}}, {Q_W{1'b1}}});
        if (v < 0)
            sat_q = '0;
        else if (v > q_max)
            sat_q = {Q_W{1'b1}};
        else
            sat_q = v[Q_W-1:0];
    endfunction

    assign accept     = (state == IDLE) && start;
    assign bad_action = (action > 4'd8);
    assign addr_calc  = ADDR_W'(state_idx) * ADDR_W'(9) + ADDR_W'(action);

    // Update arithmetic, evaluated from latched request and captured q_old.
    assign g_u         = max_q_r - (max_q_r >> GAMMA_SHIFT);
    assign g_s         = terminal_r ? '0 : $signed(CW'(g_u));
    assign target_s    = $signed({{(CW-8){reward_r[7]}}, reward_r}) + g_s;
    assign q_old_s     = $signed(CW'(q_old_r));
    assign delta_s     = target_s - q_old_s;
    assign step_s      = delta_s >>> ALPHA_SHIFT;
    assign sum_s       = q_old_s + step_s;
    assign calc_result = sat_q(sum_s);

    // State register; reset aborts any update in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state and strobe decode; strobes are pure state decodes so reset
    // forces them low immediately.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = bad_action ? DONE : RD;
            end
            RD: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                state_nx  = CAP;
            end
            CAP: begin
                busy     = 1'b1;
                state_nx = CALC;
            end
            CALC: begin
                busy     = 1'b1;
                state_nx = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                state_nx  = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, read capture, result and published q_new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= '0;
            reward_r   <= '0;
            max_q_r    <= '0;
            terminal_r <= 1'b0;
            q_old_r    <= '0;
            result_r   <= '0;
            q_new_r    <= '0;
            err_r      <= 1'b0;
        end else begin
            if (accept) begin
                reward_r   <= $signed(reward);
                max_q_r    <= max_q;
                terminal_r <= terminal;
                err_r      <= bad_action;
                if (!bad_action)
                    addr_r <= addr_calc;
            end
            if (state == CAP)
                q_old_r <= mem_rd_data;
            if (state == CALC)
                result_r <= calc_result;
            if (state == WR)
                q_new_r <= result_r;
        end
    end

    assign mem_addr    = addr_r;
    assign mem_wr_data = result_r;
    assign q_new       = q_new_r;
    assign err         = err_r;

endmodule

// File: tb/tb_q_table_updater.sv
// Directed bench for q_table_updater with a behavioural Q-table RAM.
module tb_q_table_updater;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] state_idx;
    logic [3:0]  action;
    logic [7:0]  reward;
    logic [7:0]  max_q;
    logic        terminal;
    logic        busy, done, err;
    logic [7:0]  q_new;
    logic [17:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [7:0]  mem_rd_data = 8'd0;
    logic [7:0]  mem_wr_data;

    always #5 clk = ~clk;

    q_table_updater dut (
        .clk(clk), .rst(rst), .start(start), .state_idx(state_idx),
        .action(action), .reward(reward), .max_q(max_q), .terminal(terminal),
        .busy(busy), .done(done), .err(err), .q_new(q_new),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    // RAM model with a preload port for the bench.
    logic [7:0]  mem [0:262143];
    logic        pl_we = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        else if (pl_we) mem[pl_addr] <= pl_data;
    end

    // Strobe monitor.
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [17:0] rd_addr = '0, wr_addr = '0;
    logic [7:0]  wr_data = '0;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= mem_addr;
        end
        if (mem_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wr_data;
        end
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end

    int total = 0, bad = 0;
    int last_q = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preload(input int addr, input int data);
        @(negedge clk);
        pl_addr = 18'(addr);
        pl_data = 8'(data);
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    typedef struct {
        int sidx, act, rew, mq, term, minit;
        int eaddr, eq, eerr;
    } vec_t;

    vec_t vecs [8];

    task automatic do_update(input vec_t v, input int idx);
        int rd0, wr0, done_at, busy_n, err_v, qn;
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.eerr == 0) preload(v.eaddr, v.minit);
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        state_idx = 15'(v.sidx);
        action    = 4'(v.act);
        reward    = 8'(v.rew);
        max_q     = 8'(v.mq);
        terminal  = 1'(v.term);
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        done_at = 0;
        busy_n  = 0;
        err_v   = 0;
        qn      = 0;
        for (int k = 1; k <= 8; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_at = k;
                err_v   = int'(err);
                qn      = int'(q_new);
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_latency"}, done_at, (v.eerr != 0) ? 1 : 5);
        chk({tag, "_busy_cycles"}, busy_n, (v.eerr != 0) ? 1 : 5);
        chk({tag, "_err"}, err_v, v.eerr);
        chk({tag, "_rd_count"}, rd_cnt - rd0, (v.eerr != 0) ? 0 : 1);
        chk({tag, "_wr_count"}, wr_cnt - wr0, (v.eerr != 0) ? 0 : 1);
        if (v.eerr == 0) begin
            chk({tag, "_rd_addr"}, int'(rd_addr), v.eaddr);
            chk({tag, "_wr_addr"}, int'(wr_addr), v.eaddr);
            chk({tag, "_wr_data"}, int'(wr_data), v.eq);
            chk({tag, "_mem"}, int'(mem[v.eaddr]), v.eq);
            chk({tag, "_q_new"}, qn, v.eq);
            last_q = v.eq;
        end else begin
            chk({tag, "_q_new_held"}, qn, last_q);
        end
        @(negedge clk);
        chk({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int d1, d2, rd0, wr0;

        // sidx, act, rew, mq, term, minit, eaddr, eq, eerr
        vecs[0] = '{5,     4,   20,  80, 0, 100,     49,  97, 0};
        vecs[1] = '{100,   2,  127, 255, 0, 250,    902, 255, 0};
        vecs[2] = '{19682, 8, -128, 200, 1,   2, 177146,   0, 0};
        vecs[3] = '{5,     9,   20,  80, 0,   0,      0,   0, 1};
        vecs[4] = '{1,     0,   10,   8, 0,   0,      9,   4, 0};
        vecs[5] = '{3,     7,   -5, 100, 0,  50,     34,  58, 0};
        vecs[6] = '{2,     1,  100, 255, 1,  60,     19,  70, 0};
        vecs[7] = '{4,    15,    0,   0, 0,   0,      0,   0, 1};

        rst = 1'b1; start = 1'b0; state_idx = '0; action = '0;
        reward = '0; max_q = '0; terminal = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_q_new", int'(q_new), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_strobes", int'({mem_rd_en, mem_wr_en}), 0);
        chk("reset_wr_data", int'(mem_wr_data), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_update(vecs[i], i);

        // Back-to-back with start held high through both requests.
        preload(66, 40);
        preload(77, 200);
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt; d1 = 0; d2 = 0;
        state_idx = 15'd7; action = 4'd3; reward = 8'd0; max_q = 8'd0;
        terminal = 1'b0; start = 1'b1;
        @(negedge clk);
        state_idx = 15'd8; action = 4'd5; reward = 8'd50; max_q = 8'd160;
        for (int k = 1; k <= 14; k++) begin
            if (done) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
            if (k == 8) begin
                start = 1'b0; action = 4'd9; reward = 8'd127; max_q = 8'd255;
            end
            @(negedge clk);
        end
        chk("b2b_done1", d1, 5);
        chk("b2b_done2", d2, 11);
        chk("b2b_rd_count", rd_cnt - rd0, 2);
        chk("b2b_wr_count", wr_cnt - wr0, 2);
        chk("b2b_mem_a", int'(mem[66]), 30);
        chk("b2b_mem_b", int'(mem[77]), 197);
        chk("b2b_q_new", int'(q_new), 197);

        // Reset asserted during CALC.
        preload(49, 100);
        @(negedge clk);
        state_idx = 15'd5; action = 4'd4; reward = 8'd20; max_q = 8'd80;
        terminal = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr0 = wr_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_q_new", int'(q_new), 0);
        chk("midrst_addr", int'(mem_addr), 0);
        chk("midrst_strobes", int'({mem_rd_en, mem_wr_en, done, err}), 0);
        chk("midrst_wr_data", int'(mem_wr_data), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_write", wr_cnt - wr0, 0);
        chk("midrst_mem", int'(mem[49]), 100);
        last_q = 0;
        do_update(vecs[0], 8);

        chk("rd_wr_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
